// File: rtl/wb_pkg.sv
// Shared types and helpers for the Wishbone classic master (wishbone_master_n).
package wb_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      BUS  = 1'b1
   } bus_state_t;

   localparam int WB_DATA_W = 32;
   localparam int WB_SEL_W  = 4;

   // A request with no byte enables is a read and selects the whole word.
   function automatic logic [WB_SEL_W-1:0] sel_for_req(input logic [WB_SEL_W-1:0] we);
      if (we == {WB_SEL_W{1'b0}}) begin
         return {WB_SEL_W{1'b1}};
      end else begin
         return we;
      end
   endfunction

endpackage

// File: rtl/wb_addr_decoder.sv
// Maps the slave-select field of a request address onto a one-hot slave vector.
module wb_addr_decoder
   import wb_pkg::*;
#(
   parameter int NUM_SLAVES = 4,
   parameter int SEL_LSB    = 16,
   parameter int SEL_W      = 2
) (
   input  logic [31:0]           mem_addr_i,
   output logic [NUM_SLAVES-1:0] onehot_o,
   output logic                  valid_o
);

   logic [SEL_W-1:0] idx_s;
   logic             unused_addr_s;

   assign unused_addr_s = ^mem_addr_i;

   // Index extraction, range check and one-hot expansion.
   always_comb begin
      idx_s    = mem_addr_i[SEL_LSB+SEL_W-1:SEL_LSB];
      onehot_o = {NUM_SLAVES{1'b0}};
      valid_o  = ({1'b0, idx_s} < (SEL_W+1)'(NUM_SLAVES));
      for (int i = 0; i < NUM_SLAVES; i++) begin
         onehot_o[i] = (idx_s == SEL_W'(i));
      end
   end

endmodule

// File: rtl/wishbone_master_n.sv
// Wishbone classic master bridging the uncached port to NUM_SLAVES peripherals.
// Optional bus timeout/abort path enabled by defining WB_TIMEOUT_EN.
module wishbone_master_n
   import wb_pkg::*;
#(
   parameter int NUM_SLAVES = 4,
   parameter int ADDR_W     = 16,
   parameter int SEL_LSB    = 16,
   parameter int SEL_W      = 2,
   parameter int TIMEOUT    = 255
) (
   input  logic                            clk_i,
   input  logic                            rst_n_i,
   input  logic                            mem_req_i,
   input  logic [WB_SEL_W-1:0]             mem_we_i,
   input  logic [31:0]                     mem_addr_i,
   input  logic [WB_DATA_W-1:0]            mem_data_i,
   output logic [WB_DATA_W-1:0]            mem_data_o,
   output logic                            mem_ready_o,
   output logic                            mem_err_o,
   input  logic [NUM_SLAVES-1:0]           slave_ack_i,
   input  logic [WB_DATA_W*NUM_SLAVES-1:0] slave_data_i,
   output logic [NUM_SLAVES-1:0]           slave_cyc_o,
   output logic                            wb_stb_o,
   output logic                            wb_we_o,
   output logic [WB_SEL_W-1:0]             wb_sel_o,
   output logic [ADDR_W-1:0]               wb_adr_o,
   output logic [WB_DATA_W-1:0]            wb_dat_o
);

   bus_state_t             state_q, state_d;
   logic [NUM_SLAVES-1:0]  cyc_q, cyc_d;
   logic                   stb_q, stb_d;
   logic                   we_q, we_d;
   logic [WB_SEL_W-1:0]    sel_q, sel_d;
   logic [ADDR_W-1:0]      adr_q, adr_d;
   logic [WB_DATA_W-1:0]   dat_q, dat_d;
   logic [WB_DATA_W-1:0]   rdata_q, rdata_d;
   logic                   ready_q, ready_d;
   logic                   err_q, err_d;

   logic [NUM_SLAVES-1:0]  dec_onehot_s;
   logic                   dec_valid_s;
   logic [WB_DATA_W-1:0]   rsel_s;
   logic                   ack_s;

`ifdef WB_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT);
   logic [TMO_W-1:0]       tmo_q, tmo_d;
`endif

   wb_addr_decoder #(
      .NUM_SLAVES (NUM_SLAVES),
      .SEL_LSB    (SEL_LSB),
      .SEL_W      (SEL_W)
   ) u_dec (
      .mem_addr_i (mem_addr_i),
      .onehot_o   (dec_onehot_s),
      .valid_o    (dec_valid_s)
   );

   // The registered one-hot CYC doubles as the selector, so stray ACKs/data are masked.
   always_comb begin
      rsel_s = {WB_DATA_W{1'b0}};
      for (int i = 0; i < NUM_SLAVES; i++) begin
         if (cyc_q[i]) begin
            rsel_s = rsel_s | slave_data_i[WB_DATA_W*i +: WB_DATA_W];
         end else begin
            rsel_s = rsel_s;
         end
      end
      ack_s = |(slave_ack_i & cyc_q);
   end

   // Next-state and registered-output computation.
   always_comb begin
      state_d = state_q;
      cyc_d   = cyc_q;
      stb_d   = stb_q;
      we_d    = we_q;
      sel_d   = sel_q;
      adr_d   = adr_q;
      dat_d   = dat_q;
      rdata_d = rdata_q;
      ready_d = 1'b0;
      err_d   = 1'b0;
`ifdef WB_TIMEOUT_EN
      tmo_d   = tmo_q;
`endif
      case (state_q)
         IDLE: begin
            if (mem_req_i && dec_valid_s) begin
               adr_d   = mem_addr_i[ADDR_W-1:0];
               dat_d   = mem_data_i;
               we_d    = |mem_we_i;
               sel_d   = sel_for_req(mem_we_i);
               cyc_d   = dec_onehot_s;
               stb_d   = 1'b1;
               state_d = BUS;
`ifdef WB_TIMEOUT_EN
               tmo_d   = {TMO_W{1'b0}};
`endif
            end else if (mem_req_i) begin
               ready_d = 1'b1;
               err_d   = 1'b1;
               rdata_d = {WB_DATA_W{1'b0}};
            end else begin
               state_d = IDLE;
            end
         end
         BUS: begin
            if (ack_s) begin
               cyc_d   = {NUM_SLAVES{1'b0}};
               stb_d   = 1'b0;
               ready_d = 1'b1;
               rdata_d = we_q ? {WB_DATA_W{1'b0}} : rsel_s;
               state_d = IDLE;
`ifdef WB_TIMEOUT_EN
            end else if (tmo_q == TMO_W'(TIMEOUT-1)) begin
               cyc_d   = {NUM_SLAVES{1'b0}};
               stb_d   = 1'b0;
               ready_d = 1'b1;
               err_d   = 1'b1;
               rdata_d = {WB_DATA_W{1'b0}};
               state_d = IDLE;
            end else begin
               tmo_d   = tmo_q + TMO_W'(1);
            end
`else
            end else begin
               state_d = BUS;
            end
`endif
         end
         default: begin
            state_d = IDLE;
            cyc_d   = {NUM_SLAVES{1'b0}};
            stb_d   = 1'b0;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= IDLE;
         cyc_q   <= {NUM_SLAVES{1'b0}};
         stb_q   <= 1'b0;
         we_q    <= 1'b0;
         sel_q   <= {WB_SEL_W{1'b0}};
         adr_q   <= {ADDR_W{1'b0}};
         dat_q   <= {WB_DATA_W{1'b0}};
         rdata_q <= {WB_DATA_W{1'b0}};
         ready_q <= 1'b0;
         err_q   <= 1'b0;
`ifdef WB_TIMEOUT_EN
         tmo_q   <= {TMO_W{1'b0}};
`endif
      end else begin
         state_q <= state_d;
         cyc_q   <= cyc_d;
         stb_q   <= stb_d;
         we_q    <= we_d;
         sel_q   <= sel_d;
         adr_q   <= adr_d;
         dat_q   <= dat_d;
         rdata_q <= rdata_d;
         ready_q <= ready_d;
         err_q   <= err_d;
`ifdef WB_TIMEOUT_EN
         tmo_q   <= tmo_d;
`endif
      end
   end

   assign slave_cyc_o = cyc_q;
   assign wb_stb_o    = stb_q;
   assign wb_we_o     = we_q;
   assign wb_sel_o    = sel_q;
   assign wb_adr_o    = adr_q;
   assign wb_dat_o    = dat_q;
   assign mem_data_o  = rdata_q;
   assign mem_ready_o = ready_q;
   assign mem_err_o   = err_q;

endmodule

// File: tb/tb_wishbone_master_n.sv
// Directed self-checking bench for wishbone_master_n (3 slaves, TIMEOUT=8).
module tb_wishbone_master_n;

   logic        clk = 1'b0;
   logic        rst_n_i;
   logic        mem_req_i;
   logic [3:0]  mem_we_i;
   logic [31:0] mem_addr_i;
   logic [31:0] mem_data_i;
   logic [31:0] mem_data_o;
   logic        mem_ready_o;
   logic        mem_err_o;
   logic [2:0]  slave_ack_i;
   logic [95:0] slave_data_i;
   logic [2:0]  slave_cyc_o;
   logic        wb_stb_o;
   logic        wb_we_o;
   logic [3:0]  wb_sel_o;
   logic [15:0] wb_adr_o;
   logic [31:0] wb_dat_o;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   wishbone_master_n #(
      .NUM_SLAVES (3),
      .ADDR_W     (16),
      .SEL_LSB    (16),
      .SEL_W      (2),
      .TIMEOUT    (8)
   ) dut (
      .clk_i        (clk),
      .rst_n_i      (rst_n_i),
      .mem_req_i    (mem_req_i),
      .mem_we_i     (mem_we_i),
      .mem_addr_i   (mem_addr_i),
      .mem_data_i   (mem_data_i),
      .mem_data_o   (mem_data_o),
      .mem_ready_o  (mem_ready_o),
      .mem_err_o    (mem_err_o),
      .slave_ack_i  (slave_ack_i),
      .slave_data_i (slave_data_i),
      .slave_cyc_o  (slave_cyc_o),
      .wb_stb_o     (wb_stb_o),
      .wb_we_o      (wb_we_o),
      .wb_sel_o     (wb_sel_o),
      .wb_adr_o     (wb_adr_o),
      .wb_dat_o     (wb_dat_o)
   );

   typedef struct {
      logic [3:0]  we;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          ack_cyc;
      logic [31:0] sdata;
      logic [2:0]  exp_cyc;
      logic [15:0] exp_adr;
      logic [3:0]  exp_sel;
      logic        exp_we;
      logic        exp_err;
      logic [31:0] exp_data;
   } vec_t;

   vec_t vecs [5];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", name, act, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_slave(input int s, input logic [31:0] d, input logic [2:0] ack);
      slave_data_i = {32'hBAD0_0002, 32'hBAD0_0001, 32'hBAD0_0000};
      slave_data_i[32*s +: 32] = d;
      slave_ack_i  = ack;
   endtask

   task automatic request(input logic [3:0] we, input logic [31:0] addr, input logic [31:0] d);
      mem_req_i  = 1'b1;
      mem_we_i   = we;
      mem_addr_i = addr;
      mem_data_i = d;
   endtask

   task automatic run_vec(input vec_t v);
      int s;
      s = int'(v.addr[17:16]);
      set_slave(s, v.sdata, 3'b000);
      request(v.we, v.addr, v.wdata);
      tick();
      mem_req_i = 1'b0;
      if (v.exp_err) begin
         chk("dec_ready", {31'd0, mem_ready_o}, 32'd1);
         chk("dec_err",   {31'd0, mem_err_o},   32'd1);
         chk("dec_data",  mem_data_o,           32'd0);
         chk("dec_cyc",   {29'd0, slave_cyc_o}, {29'd0, v.exp_cyc});
         chk("dec_stb",   {31'd0, wb_stb_o},    32'd0);
         tick();
         chk("dec_ready_clr", {31'd0, mem_ready_o}, 32'd0);
      end else begin
         chk("cyc", {29'd0, slave_cyc_o}, {29'd0, v.exp_cyc});
         chk("stb", {31'd0, wb_stb_o},    32'd1);
         chk("adr", {16'd0, wb_adr_o},    {16'd0, v.exp_adr});
         chk("sel", {28'd0, wb_sel_o},    {28'd0, v.exp_sel});
         chk("we",  {31'd0, wb_we_o},     {31'd0, v.exp_we});
         chk("dat", wb_dat_o,             v.wdata);
         for (int c = 1; c < v.ack_cyc; c++) begin
            chk("wait_ready", {31'd0, mem_ready_o}, 32'd0);
            tick();
            chk("wait_adr", {16'd0, wb_adr_o}, {16'd0, v.exp_adr});
         end
         set_slave(s, v.sdata, v.exp_cyc);
         tick();
         slave_ack_i = 3'b000;
         chk("done_ready", {31'd0, mem_ready_o}, 32'd1);
         chk("done_err",   {31'd0, mem_err_o},   32'd0);
         chk("done_data",  mem_data_o,           v.exp_data);
         chk("done_cyc",   {29'd0, slave_cyc_o}, 32'd0);
         chk("done_stb",   {31'd0, wb_stb_o},    32'd0);
         tick();
         chk("post_ready", {31'd0, mem_ready_o}, 32'd0);
         chk("data_hold",  mem_data_o,           v.exp_data);
      end
   endtask

   initial begin
      vecs[0] = '{we: 4'hF, addr: 32'h0001_0004, wdata: 32'hDEAD_BEEF, ack_cyc: 3,
                  sdata: 32'h1111_1111, exp_cyc: 3'b010, exp_adr: 16'h0004, exp_sel: 4'hF,
                  exp_we: 1'b1, exp_err: 1'b0, exp_data: 32'h0};
      vecs[1] = '{we: 4'h0, addr: 32'h0000_0008, wdata: 32'h0, ack_cyc: 1,
                  sdata: 32'h1234_5678, exp_cyc: 3'b001, exp_adr: 16'h0008, exp_sel: 4'hF,
                  exp_we: 1'b0, exp_err: 1'b0, exp_data: 32'h1234_5678};
      vecs[2] = '{we: 4'h0, addr: 32'h0003_0000, wdata: 32'h0, ack_cyc: 1,
                  sdata: 32'h0, exp_cyc: 3'b000, exp_adr: 16'h0, exp_sel: 4'h0,
                  exp_we: 1'b0, exp_err: 1'b1, exp_data: 32'h0};
      vecs[3] = '{we: 4'b0011, addr: 32'h0002_00A0, wdata: 32'h0000_55AA, ack_cyc: 2,
                  sdata: 32'h2222_2222, exp_cyc: 3'b100, exp_adr: 16'h00A0, exp_sel: 4'b0011,
                  exp_we: 1'b1, exp_err: 1'b0, exp_data: 32'h0};
      vecs[4] = '{we: 4'h0, addr: 32'h0002_FFFC, wdata: 32'h0, ack_cyc: 2,
                  sdata: 32'hCAFE_F00D, exp_cyc: 3'b100, exp_adr: 16'hFFFC, exp_sel: 4'hF,
                  exp_we: 1'b0, exp_err: 1'b0, exp_data: 32'hCAFE_F00D};

      rst_n_i    = 1'b0;
      mem_req_i  = 1'b0;
      mem_we_i   = 4'h0;
      mem_addr_i = 32'h0;
      mem_data_i = 32'h0;
      set_slave(0, 32'h0, 3'b000);
      tick();
      tick();
      chk("rst_cyc",   {29'd0, slave_cyc_o}, 32'd0);
      chk("rst_stb",   {31'd0, wb_stb_o},    32'd0);
      chk("rst_ready", {31'd0, mem_ready_o}, 32'd0);
      chk("rst_err",   {31'd0, mem_err_o},   32'd0);
      chk("rst_data",  mem_data_o,           32'd0);
      chk("rst_adr",   {16'd0, wb_adr_o},    32'd0);
      rst_n_i = 1'b1;
      tick();

      for (int i = 0; i < 5; i++) begin
         run_vec(vecs[i]);
      end

      // Spurious ACK from slave 2 plus an ignored request while in BUS.
      set_slave(0, 32'h600D_CAFE, 3'b000);
      request(4'h0, 32'h0000_0010, 32'h0);
      tick();
      chk("sp_cyc", {29'd0, slave_cyc_o}, 32'd1);
      request(4'hF, 32'h0001_0000, 32'h7777_7777);
      slave_ack_i = 3'b100;
      tick();
      mem_req_i = 1'b0;
      chk("sp_cyc_hold", {29'd0, slave_cyc_o}, 32'd1);
      chk("sp_adr_hold", {16'd0, wb_adr_o},    32'h0010);
      chk("sp_no_ready", {31'd0, mem_ready_o}, 32'd0);
      slave_ack_i = 3'b001;
      tick();
      slave_ack_i = 3'b000;
      chk("sp_ready", {31'd0, mem_ready_o}, 32'd1);
      chk("sp_data",  mem_data_o,           32'h600D_CAFE);
      // Back-to-back request in the ready cycle.
      request(4'hF, 32'h0001_0020, 32'hA5A5_5A5A);
      tick();
      mem_req_i = 1'b0;
      chk("b2b_cyc", {29'd0, slave_cyc_o}, 32'd2);
      chk("b2b_adr", {16'd0, wb_adr_o},    32'h0020);
      chk("b2b_dat", wb_dat_o,             32'hA5A5_5A5A);
      slave_ack_i = 3'b010;
      tick();
      slave_ack_i = 3'b000;
      chk("b2b_ready", {31'd0, mem_ready_o}, 32'd1);
      chk("b2b_data",  mem_data_o,           32'd0);
      tick();

`ifdef WB_TIMEOUT_EN
      // No ACK: CYC visible for 8 BUS cycles, then abort with error.
      request(4'h0, 32'h0000_0040, 32'h0);
      tick();
      mem_req_i = 1'b0;
      for (int c = 1; c <= 8; c++) begin
         chk("to_cyc", {29'd0, slave_cyc_o}, 32'd1);
         chk("to_no_ready", {31'd0, mem_ready_o}, 32'd0);
         tick();
      end
      chk("to_cyc_drop", {29'd0, slave_cyc_o}, 32'd0);
      chk("to_stb_drop", {31'd0, wb_stb_o},    32'd0);
      chk("to_ready",    {31'd0, mem_ready_o}, 32'd1);
      chk("to_err",      {31'd0, mem_err_o},   32'd1);
      chk("to_data",     mem_data_o,           32'd0);
      tick();
      chk("to_ready_clr", {31'd0, mem_ready_o}, 32'd0);
      // ACK exactly on the expiry cycle wins.
      set_slave(0, 32'h0BAD_F00D, 3'b000);
      request(4'h0, 32'h0000_0044, 32'h0);
      tick();
      mem_req_i = 1'b0;
      for (int c = 1; c < 8; c++) begin
         tick();
      end
      slave_ack_i = 3'b001;
      tick();
      slave_ack_i = 3'b000;
      chk("toack_ready", {31'd0, mem_ready_o}, 32'd1);
      chk("toack_err",   {31'd0, mem_err_o},   32'd0);
      chk("toack_data",  mem_data_o,           32'h0BAD_F00D);
      tick();
`endif

      // Asynchronous reset in the middle of a BUS cycle.
      request(4'h0, 32'h0001_0000, 32'h0);
      tick();
      mem_req_i = 1'b0;
      chk("ar_cyc_pre", {29'd0, slave_cyc_o}, 32'd2);
      #2;
      rst_n_i = 1'b0;
      #1;
      chk("ar_cyc",   {29'd0, slave_cyc_o}, 32'd0);
      chk("ar_stb",   {31'd0, wb_stb_o},    32'd0);
      chk("ar_data",  mem_data_o,           32'd0);
      tick();
      rst_n_i = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         chk("ar_no_ready", {31'd0, mem_ready_o}, 32'd0);
         chk("ar_no_cyc",   {29'd0, slave_cyc_o}, 32'd0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
